hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the 5-stage RISC-V core (F/D/E/M/W). It selects ALU operand forwarding sources for the Execute stage, stalls on load-use dependences and flushes on taken branches/jumps. All control outputs are combinational; the only state is a pair of saturating event counters that report hazard activity to the debug/performance block.

## Interface
- `CNT_W`, default 32: width of each performance counter.
- `clk`  in  1  pipeline clock; counters update on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; clears the counters.
- `RegSource1D`, `RegSource2D`  in  5 each  rs1/rs2 of the instruction in Decode.
- `RegSource1E`, `RegSource2E`  in  5 each  rs1/rs2 of the instruction in Execute.
- `RegDestinE`  in  5  rd of the instruction in Execute.
- `RegDestinM`  in  5  rd of the instruction in Memory.
- `RegDestinW`  in  5  rd of the instruction in Writeback.
- `RegWriteM`  in  1  Memory-stage instruction writes the register file.
- `RegWriteW`  in  1  Writeback-stage instruction writes the register file.
- `ResultSrcE0`  in  1  the Execute-stage instruction is a load (result comes from memory).
- `PCSrcE`  in  1  a branch/jump resolved as taken in Execute.
- `CountClear`  in  1  synchronous clear of both counters.
- `ForwardAE`, `ForwardBE`  out  2 each  SrcA/SrcB mux select: 00 register file, 01 ResultW, 10 ALUResultM; 11 is never driven.
- `StallF`, `StallD`  out  1 each  hold the PC and the F/D register.
- `FlushD`, `FlushE`  out  1 each  clear the F/D and D/E registers.
- `StallCount`, `FlushCount`  out  `CNT_W` each  hazard event counters.

## Operation
- ForwardAE, all conditions ANDed in each case:
  - 10 when RegWriteM is 1, RegDestinM equals RegSource1E, and RegSource1E is not 0.
  - Otherwise 01 when RegWriteW is 1, RegDestinW equals RegSource1E, and RegSource1E is not 0.
  - Otherwise 00.
- ForwardBE: same rule, using RegSource2E.
- Memory beats Writeback when both match.
- Register x0 is never forwarded. A match with the write-enable low gives 00.
- lwStall is 1 when all of these hold:
  - ResultSrcE0 is 1;
  - RegDestinE is not 0;
  - RegDestinE equals RegSource1D or RegSource2D.
- StallF = StallD = lwStall.
- FlushD = PCSrcE.
- FlushE = lwStall OR PCSrcE.
- lwStall and PCSrcE together: both stall and flush outputs assert. The flush takes precedence in the pipeline registers; that is the pipeline's concern, not this block's.
- Counters:
  - StallCount adds 1 on each clock with lwStall = 1.
  - FlushCount adds 1 on each clock with PCSrcE = 1.
  - Both saturate at all-ones and never wrap.
  - CountClear = 1 zeroes both on the next edge and overrides increments.

## Timing
- Forward/stall/flush outputs are purely combinational from current inputs: zero-cycle latency, no registered path.
- These outputs do not depend on clk or rst_n; they are valid during reset.
- Counter reset value is 0.
- Reset asserted mid-operation zeroes the counters immediately (asynchronously).
- Counters resume counting on the first rising edge after rst_n deasserts.
- A stall held for N cycles adds N to StallCount.

## Structure
- The shared pipeline package holds:
  - the forward-select encodings FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;
  - the register-index width constant (5).
- One sub-module, `hazard_fwd_sel`, holds the forwarding priority logic. It is instantiated twice, once for the A operand and once for the B operand.
- The stall/flush logic and the counters stay in `hazard_unit`.

## Test plan
- Mixed forwarding: RegSource1E=5, RegSource2E=2, RegDestinM=5, RegDestinW=2, RegWriteM=1, RegWriteW=1 -> ForwardAE=10 and ForwardBE=01.
- Swapped forwarding: RegSource1E=5, RegSource2E=2, RegDestinM=2, RegDestinW=5, RegWriteM=1, RegWriteW=1 -> ForwardAE=01 and ForwardBE=10.
- x0 and disabled writes: RegSource1E=0, RegSource2E=2, RegDestinM=0, RegDestinW=5, RegWriteM=0, RegWriteW=0 -> ForwardAE=00 and ForwardBE=00.
- Priority: RegSource1E=7, RegDestinM=7, RegDestinW=7, both write-enables 1 -> ForwardAE=10.
- Load-use stall: ResultSrcE0=1, RegDestinE=3, RegSource2D=3 for 2 clocks -> StallF=StallD=FlushE=1, FlushD=0, StallCount=2. Then RegDestinE=0 -> no stall.
- Branch and reset: PCSrcE=1 for 3 clocks -> FlushD=FlushE=1 and FlushCount=3. Then rst_n=0 -> both counters 0 immediately.
- Saturation: CNT_W=2 with 5 stall cycles -> StallCount=3.
- Clear: CountClear=1 -> both counters 0 on the next edge.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared pipeline constants: register-index width and operand forward-select encodings.
package hazard_unit_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward-source priority for one Execute-stage ALU operand.
// Memory wins over Writeback because it holds the younger result.
module hazard_fwd_sel
    import hazard_unit_pkg::*;
(
    input  logic [REG_W-1:0] src_i,
    input  logic [REG_W-1:0] dst_m_i,
    input  logic [REG_W-1:0] dst_w_i,
    input  logic             wr_m_i,
    input  logic             wr_w_i,
    output logic [1:0]       fwd_o
);

    logic src_nz;

    // x0 is hardwired to zero, so it is never forwarded.
    assign src_nz = (src_i != '0);

    always_comb begin
        fwd_o = FWD_RF;
        if (wr_m_i && (dst_m_i == src_i) && src_nz) begin
            fwd_o = FWD_MEM;
        end else if (wr_w_i && (dst_w_i == src_i) && src_nz) begin
            fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: combinational forwarding/stall/flush control
// plus saturating stall and flush event counters.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] RegSource1D,
    input  logic [REG_W-1:0] RegSource2D,
    input  logic [REG_W-1:0] RegSource1E,
    input  logic [REG_W-1:0] RegSource2E,
    input  logic [REG_W-1:0] RegDestinE,
    input  logic [REG_W-1:0] RegDestinM,
    input  logic [REG_W-1:0] RegDestinW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             CountClear,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    logic             lw_stall;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    hazard_fwd_sel u_fwd_a (
        .src_i   (RegSource1E),
        .dst_m_i (RegDestinM),
        .dst_w_i (RegDestinW),
        .wr_m_i  (RegWriteM),
        .wr_w_i  (RegWriteW),
        .fwd_o   (ForwardAE)
    );

    hazard_fwd_sel u_fwd_b (
        .src_i   (RegSource2E),
        .dst_m_i (RegDestinM),
        .dst_w_i (RegDestinW),
        .wr_m_i  (RegWriteM),
        .wr_w_i  (RegWriteW),
        .fwd_o   (ForwardBE)
    );

    // A load in Execute whose rd feeds the Decode instruction must hold one cycle.
    assign lw_stall = ResultSrcE0 && (RegDestinE != '0) &&
                      ((RegDestinE == RegSource1D) || (RegDestinE == RegSource2D));

    assign StallF = lw_stall;
    assign StallD = lw_stall;
    assign FlushD = PCSrcE;
    assign FlushE = lw_stall || PCSrcE;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (CountClear) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (lw_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
            if (PCSrcE && (flush_cnt_q != '1))   flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding, load-use stall, branch flush,
// counter reset/saturation/clear, using a 32-bit and a 2-bit counter instance.
module tb_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic [4:0] RegSource1D, RegSource2D, RegSource1E, RegSource2E;
    logic [4:0] RegDestinE, RegDestinM, RegDestinW;
    logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, CountClear;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, FlushD, FlushE;
    logic [31:0] StallCount, FlushCount;

    logic [1:0] s_ForwardAE, s_ForwardBE;
    logic       s_StallF, s_StallD, s_FlushD, s_FlushE;
    logic [1:0] s_StallCount, s_FlushCount;

    logic [31:0] exp_q[$];
    int tests_run = 0;
    int tests_failed = 0;

    hazard_unit dut (
        .clk(clk), .rst_n(rst_n),
        .RegSource1D(RegSource1D), .RegSource2D(RegSource2D),
        .RegSource1E(RegSource1E), .RegSource2E(RegSource2E),
        .RegDestinE(RegDestinE), .RegDestinM(RegDestinM), .RegDestinW(RegDestinW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .CountClear(CountClear),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    hazard_unit #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .RegSource1D(RegSource1D), .RegSource2D(RegSource2D),
        .RegSource1E(RegSource1E), .RegSource2E(RegSource2E),
        .RegDestinE(RegDestinE), .RegDestinM(RegDestinM), .RegDestinW(RegDestinW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .CountClear(CountClear),
        .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE),
        .StallF(s_StallF), .StallD(s_StallD), .FlushD(s_FlushD), .FlushE(s_FlushE),
        .StallCount(s_StallCount), .FlushCount(s_FlushCount)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model of one operand's forward select
    function automatic logic [1:0] fwd_model(input logic [4:0] s, input logic [4:0] dm,
                                             input logic [4:0] dw, input logic wm,
                                             input logic ww);
        if (wm && (dm == s) && (s != 5'd0)) return 2'b10;
        if (ww && (dw == s) && (s != 5'd0)) return 2'b01;
        return 2'b00;
    endfunction

    // driver tasks
    task automatic drive_idle();
        RegSource1D = 0; RegSource2D = 0; RegSource1E = 0; RegSource2E = 0;
        RegDestinE = 0; RegDestinM = 0; RegDestinW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0; CountClear = 0;
    endtask

    task automatic drive_fwd(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] dm,
                             input logic [4:0] dw, input logic wm, input logic ww);
        RegSource1E = s1; RegSource2E = s2; RegDestinM = dm; RegDestinW = dw;
        RegWriteM = wm; RegWriteW = ww;
    endtask

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    // scoreboard: pop the oldest expectation and compare
    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s: observed %0h, no expected value queued", tag, obs);
            return;
        end
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd_obs();
        return {28'd0, ForwardAE, ForwardBE};
    endfunction

    function automatic logic [31:0] flag_obs();
        return {28'd0, StallF, StallD, FlushD, FlushE};
    endfunction

    initial begin
        drive_idle();
        rst_n = 1'b0;
        #12;

        push(32'd0); check("reset_stall_cnt", StallCount);
        push(32'd0); check("reset_flush_cnt", FlushCount);

        // forwarding is combinational and must work while in reset
        drive_fwd(5, 2, 5, 2, 1, 1);
        push(32'b1001); #1; check("fwd_mixed_in_reset", fwd_obs());

        @(negedge clk) rst_n = 1'b1;

        drive_fwd(5, 2, 2, 5, 1, 1);
        push(32'b0110); #1; check("fwd_swapped", fwd_obs());

        drive_fwd(0, 2, 0, 5, 0, 0);
        push(32'b0000); #1; check("fwd_x0_disabled", fwd_obs());

        drive_fwd(7, 7, 7, 7, 1, 1);
        push(32'b1010); #1; check("fwd_priority_mem", fwd_obs());

        drive_fwd(7, 7, 7, 7, 0, 1);
        push(32'b0101); #1; check("fwd_mem_we_low", fwd_obs());

        drive_fwd(0, 0, 0, 0, 1, 1);
        push(32'b0000); #1; check("fwd_x0_enabled", fwd_obs());

        for (int i = 0; i < 10; i++) begin
            logic [4:0] s1, s2, dm, dw;
            logic wm, ww;
            s1 = 5'($urandom_range(0, 3)); s2 = 5'($urandom_range(0, 3));
            dm = 5'($urandom_range(0, 3)); dw = 5'($urandom_range(0, 3));
            wm = 1'($urandom_range(0, 1)); ww = 1'($urandom_range(0, 1));
            drive_fwd(s1, s2, dm, dw, wm, ww);
            push({28'd0, fwd_model(s1, dm, dw, wm, ww), fwd_model(s2, dm, dw, wm, ww)});
            #1; check("fwd_random", fwd_obs());
        end

        // load-use stall for two clocks
        @(negedge clk);
        drive_idle();
        ResultSrcE0 = 1; RegDestinE = 3; RegSource2D = 3;
        push(32'b1101); #1; check("lw_stall_flags", flag_obs());
        @(posedge clk); @(posedge clk); @(negedge clk);
        push(32'd2); check("lw_stall_cnt", StallCount);
        push(32'd0); check("lw_flush_cnt_idle", FlushCount);
        RegDestinE = 0;
        push(32'b0000); #1; check("lw_rd_x0_no_stall", flag_obs());
        RegDestinE = 3; RegSource2D = 0; RegSource1D = 3; ResultSrcE0 = 0;
        push(32'b0000); #1; check("non_load_no_stall", flag_obs());
        @(posedge clk); @(negedge clk);
        push(32'd2); check("stall_cnt_held", StallCount);

        // taken branch for three clocks, then asynchronous reset mid-cycle
        drive_idle();
        PCSrcE = 1;
        push(32'b0011); #1; check("branch_flags", flag_obs());
        @(posedge clk); @(posedge clk); @(posedge clk); @(negedge clk);
        push(32'd3); check("branch_flush_cnt", FlushCount);
        #2 rst_n = 1'b0;
        #1;
        push(32'd0); check("async_rst_stall_cnt", StallCount);
        push(32'd0); check("async_rst_flush_cnt", FlushCount);
        @(posedge clk); #1;
        push(32'd0); check("rst_held_flush_cnt", FlushCount);

        // saturation on the 2-bit instance over five stall cycles
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        ResultSrcE0 = 1; RegDestinE = 9; RegSource1D = 9;
        repeat (5) @(posedge clk);
        @(negedge clk);
        push(32'd5); check("stall_cnt_5", StallCount);
        push(32'd3); check("sat_stall_cnt", {30'd0, s_StallCount});

        // stall and branch together
        PCSrcE = 1;
        push(32'b1111); #1; check("stall_and_flush_flags", flag_obs());
        @(posedge clk); @(negedge clk);
        push(32'd6); check("both_stall_cnt", StallCount);
        push(32'd1); check("both_flush_cnt", FlushCount);
        push(32'd3); check("sat_stall_held", {30'd0, s_StallCount});
        push(32'd1); check("sat_flush_cnt", {30'd0, s_FlushCount});

        // clear overrides active increments
        CountClear = 1;
        @(posedge clk); @(negedge clk);
        push(32'd0); check("clear_stall_cnt", StallCount);
        push(32'd0); check("clear_flush_cnt", FlushCount);
        push(32'd0); check("clear_sat_stall_cnt", {30'd0, s_StallCount});
        CountClear = 0;
        @(posedge clk); @(negedge clk);
        push(32'd1); check("post_clear_stall_cnt", StallCount);
        push(32'd1); check("post_clear_flush_cnt", FlushCount);

        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_drain: observed %0d leftover, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
